// File: rtl/metropolis_judge.sv
// Metropolis acceptance judge: 15-step Horner-form Taylor series for exp(x), followed by a uniform-random compare.
// Define METROPOLIS_ROUND_EN to round both Q15 rescaling shifts to nearest; left undefined, they truncate toward -inf.
module metropolis_judge #(
   parameter int X_W   = 20,
   parameter int ACC_W = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  exp_init,
   input  logic                  exp_run,
   input  logic                  exp_fin,
   input  logic [16:0]           exp_recip,
   input  logic signed [X_W-1:0] delta_x,
   input  logic [14:0]           rand_val,
   output logic                  busy,
   output logic [15:0]           exp_value,
   output logic                  judge_valid,
   output logic                  judge_accept
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int PX_W = X_W + 17;
   localparam int PA_W = X_W + ACC_W;

   localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(32768);
   localparam logic signed [X_W-1:0]   X_FLOOR = X_W'(-131072);
`ifdef METROPOLIS_ROUND_EN
   localparam logic signed [PX_W-1:0]  X_HALF  = PX_W'(16384);
   localparam logic signed [PA_W-1:0]  A_HALF  = PA_W'(16384);
`endif

   logic [1:0]              state;
   logic signed [X_W-1:0]   x;
   logic signed [ACC_W-1:0] acc;
   logic                    stepped;

   logic signed [PX_W-1:0]  x_ext;
   logic signed [PX_W-1:0]  r_ext;
   logic signed [PX_W-1:0]  xr_adj;
   logic signed [X_W-1:0]   p;
   logic signed [PA_W-1:0]  p_ext;
   logic signed [PA_W-1:0]  a_ext;
   logic signed [PA_W-1:0]  pa_adj;
   logic signed [ACC_W-1:0] acc_step;
   logic [15:0]             result;
   logic                    unused_bits;

   assign busy = (state == ST_EVAL);

   // One Horner step: p = x/k, then acc = 1 + p*acc; |p| <= |x| so the narrow slice of the first product is exact.
   always_comb begin
      x_ext = {{17{x[X_W-1]}}, x};
      r_ext = {{X_W{1'b0}}, exp_recip};
`ifdef METROPOLIS_ROUND_EN
      xr_adj = (x_ext * r_ext) + X_HALF;
`else
      xr_adj = x_ext * r_ext;
`endif
      p     = xr_adj[X_W+14:15];
      p_ext = {{ACC_W{p[X_W-1]}}, p};
      a_ext = {{X_W{acc[ACC_W-1]}}, acc};
`ifdef METROPOLIS_ROUND_EN
      pa_adj = (p_ext * a_ext) + A_HALF;
`else
      pa_adj = p_ext * a_ext;
`endif
      acc_step = ONE + pa_adj[ACC_W+14:15];
   end

   assign unused_bits = ^{xr_adj[PX_W-1:X_W+15], xr_adj[14:0], pa_adj[PA_W-1:ACC_W+15], pa_adj[14:0]};

   // Out-of-range x values bypass the series; otherwise clamp the accumulator into 0..1.0.
   always_comb begin
      result = 16'd0;
      if (!x[X_W-1]) begin
         result = 16'h8000;
      end else if (x <= X_FLOOR) begin
         result = 16'd0;
      end else if (acc[ACC_W-1]) begin
         result = 16'd0;
      end else if (acc > ONE) begin
         result = 16'h8000;
      end else begin
         result = acc[15:0];
      end
   end

   // The verdict uses the held result before any same-cycle init restarts the evaluation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         x            <= '0;
         acc          <= '0;
         stepped      <= 1'b0;
         exp_value    <= '0;
         judge_valid  <= 1'b0;
         judge_accept <= 1'b0;
      end else begin
         judge_valid <= 1'b0;
         if ((state == ST_DONE) && exp_fin) begin
            judge_valid  <= 1'b1;
            judge_accept <= ({1'b0, rand_val} < exp_value);
         end
         if (exp_init) begin
            x       <= delta_x;
            acc     <= ONE;
            stepped <= 1'b0;
            state   <= ST_EVAL;
         end else begin
            case (state)
               ST_EVAL: begin
                  if (exp_run) begin
                     acc     <= acc_step;
                     stepped <= 1'b1;
                  end else if (stepped) begin
                     exp_value <= result;
                     state     <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  if (exp_fin) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/metropolis_judge.md
# metropolis_judge

Downstream consumer of the node controller's exponential-unit sequencing (`exp_init` / `exp_run` / `exp_fin` / `exp_recip`). It evaluates exp(x) for the Metropolis acceptance probability with a 15-step Horner-form Taylor series, driven by the controller's reciprocal stream 1/15 … 1/1. At `exp_fin` it compares the result against a supplied uniform random value and emits a one-cycle accept/reject verdict to the replica update logic.

## Interface
Parameters:
- `X_W`, 20: width of signed input x, Q4.15 format.
- `ACC_W`, 24: width of signed Horner accumulator, Q8.15 format.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `exp_init`  in  1  start pulse; captures `delta_x`.
- `exp_run`  in  1  high for each Horner step; `exp_recip` is valid while it is high.
- `exp_fin`  in  1  judge strobe.
- `exp_recip`  in  17  unsigned 1/k, Q2.15 (1.0 = 32768).
- `delta_x`  in  X_W  signed x = −ΔE·β, Q4.15.
- `rand_val`  in  15  uniform random value, Q0.15, sampled on `exp_fin`.
- `busy`  out  1  evaluation in progress.
- `exp_value`  out  16  clamped exp(x), Q1.15, range 0..32768.
- `judge_valid`  out  1  one-cycle verdict pulse.
- `judge_accept`  out  1  verdict; meaningful only when `judge_valid` is high.

## Operation
- **States:** IDLE, EVAL, DONE.
- **`exp_init` in any state:**
  - Latch `x <= delta_x`.
  - Set `acc <= 32768`.
  - Go to EVAL, `busy = 1`.
  - An init arriving during EVAL or DONE restarts the evaluation and discards any pending result.
- **EVAL, each cycle with `exp_run` = 1:**
  - `p = (x · exp_recip) >>> 15`
  - `acc <= 32768 + ((p · acc) >>> 15)`
  - Arithmetic shifts. Products are full width: 37 bits and X_W+ACC_W bits.
- **EVAL → DONE:** on the first cycle with `exp_run` = 0 after at least one step.
  - `exp_value <= clamp(acc, 0, 32768)`.
  - Forced results override the clamp:
    - x ≥ 0 forces 32768.
    - x ≤ −131072 (−4.0) forces 0.
  - `busy` drops.
- **`exp_fin` in DONE:**
  - `judge_valid <= 1` for one cycle.
  - `judge_accept <= ({1'b0, rand_val} < exp_value)`.
  - Go to IDLE.
- **`exp_fin` in IDLE or EVAL:** ignored. No `judge_valid`, no state change.
- **`exp_run` in IDLE or DONE:** ignored.
- **Accumulator range:** for −4 < x ≤ 0 the accumulator stays within ±256, so no overflow handling is required.

## Timing
- **Reset values:** state IDLE, `busy` 0, `exp_value` 0, `judge_valid` 0, `judge_accept` 0, `acc` 0, `x` 0.
- **Reset mid-EVAL:** aborts the evaluation; the next `exp_fin` produces no verdict.
- **Nominal schedule, with `exp_init` at cycle T:**
  - Recips 1/15 … 1/1 arrive with `exp_run` high on T+1 … T+15.
  - `exp_value` is valid and `busy` low from T+17.
- **Verdict:** `judge_valid` and `judge_accept` are registered, appearing the cycle after `exp_fin`.
- **Simultaneous `exp_init` and `exp_fin` in DONE:** the verdict for the old result is issued, and the new evaluation starts the same cycle.
- **`exp_value`:** holds until the next DONE entry or reset.

## Configuration
- **`METROPOLIS_ROUND_EN` defined:**
  - Both `>>> 15` operations round to nearest: add 2^14 before the shift.
  - Tolerance versus ideal exp: ±2 LSB.
- **Undefined:**
  - Truncation toward −∞.
  - Tolerance versus ideal exp: ±6 LSB.
- Control timing is identical in both builds.

## Test plan
- **Zero input:** init with `delta_x` = 0, 15 run cycles, fin with `rand_val` = 32767 → `exp_value` = 32768, `judge_accept` = 1.
- **x = −1.0:** `delta_x` = −32768 → `exp_value` = 12055 within tolerance. `rand_val` 12000 → accept; `rand_val` 12100 → reject.
- **Clamp boundaries:**
  - `delta_x` = −131072 → `exp_value` = 0, `rand_val` 0 → reject.
  - `delta_x` = +16384 → `exp_value` = 32768 → accept.
- **Fin without result:**
  - `exp_fin` in IDLE → no `judge_valid`.
  - `exp_fin` during EVAL, at T+8 → no `judge_valid`, and the evaluation completes normally.
- **Abort and restart:**
  - Reset at T+7 → outputs return to reset values, and the subsequent fin gives no verdict.
  - Re-init at T+5 with x = −0.5 → `exp_value` = 19874 within tolerance.
- **Back-to-back evaluations:** inits at cycles 40 and 60 with fins at 58 and 78 → two independent verdicts, each matching its own x.
